mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs (address, store data, control) and performs the data-memory transaction on a req/gnt/rvalid bus.
- Generates byte enables and store-data lane shifting, and extracts and sign/zero-extends load data.
- Freezes the pipeline through stall_o while a transaction is outstanding.
- Sits between the EX/MEM and MEM/WB registers.

Parameters:
- TIMEOUT_CYC, 64, cycles allowed from request issue to response before a bus error is declared (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_read_m  in  1  load in MEM stage
- mem_write_m  in  1  store in MEM stage (mutually exclusive with mem_read_m)
- funct3_m  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_m  in  32  effective byte address
- write_data_m  in  32  store data, right-aligned
- flush_m  in  1  squash MEM instruction (no new request issued)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {alu_result_m[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response valid
- dmem_rdata  in  32  read word
- dmem_err  in  1  response error, qualified by dmem_rvalid
- read_data_m  out  32  extended load result, registered
- stall_o  out  1  freeze IF..MEM, combinational
- misalign_o  out  1  one-cycle misaligned-access pulse, registered
- bus_err_o  out  1  one-cycle bus error/timeout pulse, registered

Behaviour:
- Reset: state IDLE; read_data_m=0; misalign_o=0; bus_err_o=0; dmem_req=0; timeout counter=0. Reset mid-transaction drops the request immediately and ignores any later rvalid.
- States: IDLE, REQ, WAIT, DONE.
- access = (mem_read_m|mem_write_m) & ~flush_m.
- Alignment rules:
  - H/HU is aligned when addr[0]=0.
  - W is aligned when addr[1:0]=0.
  - B is always aligned.
  - funct3 011/110/111 with an access is treated as misaligned.
- IDLE:
  - access & aligned -> REQ; stall_o=1 in that same cycle.
  - access & ~aligned -> misalign_o=1 next cycle, no request, no stall, state stays IDLE.
- REQ: dmem_req=1; addr/we/be/wdata are held stable from the registered copy of the access until dmem_gnt. On req&gnt -> WAIT.
- WAIT: dmem_req=0. On dmem_rvalid -> DONE.
  - For a load, capture the extracted data into read_data_m.
  - If dmem_err, read_data_m=0 and pulse bus_err_o.
  - A store's response data is ignored; its dmem_err is still reported.
- Timeout: the counter clears on entering REQ and increments every cycle in REQ/WAIT. When it reaches TIMEOUT_CYC-1 without completion:
  - read_data_m=0, bus_err_o pulses, go to DONE.
  - A late rvalid is then ignored.
- DONE: stall_o=0 for exactly one cycle so the pipeline advances; unconditionally -> IDLE.
- stall_o = (IDLE & access & aligned) | REQ | WAIT. Minimum load/store latency is 3 cycles (IDLE, REQ+gnt, WAIT+rvalid same-cycle not permitted; rvalid earliest in the cycle after gnt), plus DONE.
- flush_m asserted while in REQ/WAIT does not cancel the transaction; the request completes.
- Byte enables from addr[1:0]:
  - B: 0001<<a
  - H: 0011<<a
  - W: 1111
- wdata: B replicated ×4; H replicated ×2; W as-is.
- Load extract: byte at lane addr[1:0], half at lane addr[1]. Sign-extend for B/H, zero-extend for BU/HU.
- read_data_m holds its value until the next completed load.

Decomposition:
- Package mem_stage_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum lsu_state_t
  - TIMEOUT counter width (8)
- Sub-module lsu_align: purely combinational. Takes funct3 + addr[1:0] + wdata/rdata and produces be, shifted wdata, extended rdata, and aligned flag. It is instantiated once.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> be=1111, read_data_m=0xDEADBEEF, stall_o high 3 cycles then low in DONE.
- LB addr 0x103, rdata 0x80FF_FF_FF -> be=1000, read_data_m=0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x202, write_data_m=0x0000ABCD, gnt delayed 4 cycles -> dmem_be=1100, dmem_wdata=0xABCDABCD held stable through the wait, dmem_we=1.
- LW addr 0x101 -> no dmem_req, misalign_o=1 for one cycle, stall_o never asserted.
- Load with gnt but no rvalid for TIMEOUT_CYC=64 -> bus_err_o pulse, read_data_m=0, return to IDLE; a late rvalid is ignored.
- Assert rst during WAIT -> dmem_req=0, state IDLE, read_data_m=0, stall_o=0 immediately; a following rvalid has no effect.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store-lane replication and load extraction/extension.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_aligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = i_wdata;
    o_rdata   = i_rdata;
    o_aligned = 1'b0;
    unique case (i_funct3)
      F3_B, F3_BU: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        o_aligned = 1'b1;
      end
      F3_H, F3_HU: begin
        o_be      = 4'b0011 << i_addr_lo;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        o_aligned = ~i_addr_lo[0];
      end
      F3_W: begin
        o_be      = 4'b1111;
        o_aligned = (i_addr_lo == 2'b00);
      end
      // Reserved encodings stay unaligned so they raise misalign instead of reaching the bus.
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid transaction per memory instruction,
// with pipeline stall, misalign detection and response timeout.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic        flush_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic [31:0] read_data_m,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  lsu_state_t           r_state;
  logic [29:0]          r_addr;
  logic [1:0]           r_addr_lo;
  logic [2:0]           r_funct3;
  logic                 r_we;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic [31:0]          r_read_data;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_misalign;
  logic                 r_bus_err;

  logic        w_access;
  logic        w_idle;
  logic [2:0]  w_funct3;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_aligned;
  logic        w_timeout;

  assign w_access = (mem_read_m | mem_write_m) & ~flush_m;
  assign w_idle   = (r_state == StIdle);

  // The single aligner sees the live access in IDLE and the captured access afterwards.
  assign w_funct3  = w_idle ? funct3_m : r_funct3;
  assign w_addr_lo = w_idle ? alu_result_m[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_funct3  (w_funct3),
    .i_addr_lo (w_addr_lo),
    .i_wdata   (write_data_m),
    .i_rdata   (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_aligned (w_aligned)
  );

  assign w_timeout = (r_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_addr_lo   <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_cnt       <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_access && w_aligned) begin
            r_state   <= StReq;
            r_addr    <= alu_result_m[31:2];
            r_addr_lo <= alu_result_m[1:0];
            r_funct3  <= funct3_m;
            r_we      <= mem_write_m;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_cnt     <= '0;
          end else if (w_access) begin
            r_misalign <= 1'b1;
          end
        end
        StReq: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_state   <= StDone;
            r_bus_err <= 1'b1;
            if (!r_we) r_read_data <= '0;
          end else if (dmem_gnt) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_rvalid) begin
            r_state   <= StDone;
            r_bus_err <= dmem_err;
            if (!r_we) r_read_data <= dmem_err ? 32'h0 : w_rdata;
          end else if (w_timeout) begin
            r_state   <= StDone;
            r_bus_err <= 1'b1;
            if (!r_we) r_read_data <= '0;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dmem_req    = (r_state == StReq);
  assign dmem_we     = r_we;
  assign dmem_addr   = {r_addr, 2'b00};
  assign dmem_be     = r_be;
  assign dmem_wdata  = r_wdata;
  assign read_data_m = r_read_data;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_bus_err;
  assign stall_o     = (w_idle & w_access & w_aligned) | (r_state == StReq) |
                       (r_state == StWait);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: drives the pipeline side and plays the memory bus.
module tb_mem_stage_lsu;

  localparam int unsigned TimeoutCyc = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m, flush_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data_m;
  logic        stall_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  mem_stage_lsu #(.TIMEOUT_CYC(TimeoutCyc)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .flush_m      (flush_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .dmem_err     (dmem_err),
    .read_data_m  (read_data_m),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the expected load result is queued at issue and popped in DONE.
  task automatic do_access(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_dly, input logic [31:0] rdata,
                           input logic err, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic flush_mid);
    mem_read_m   = is_load;
    mem_write_m  = !is_load;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    sb_q.push_back(exp_rd);
    #1;
    check("idle_stall", 32'(stall_o), 32'd1);
    check("idle_req", 32'(dmem_req), 32'd0);
    step();
    if (flush_mid) flush_m = 1'b1;
    for (int i = 0; i <= gnt_dly; i++) begin
      dmem_gnt = (i == gnt_dly);
      #1;
      check("req", 32'(dmem_req), 32'd1);
      check("req_stall", 32'(stall_o), 32'd1);
      check("addr", dmem_addr, {addr[31:2], 2'b00});
      check("be", 32'(dmem_be), 32'(exp_be));
      check("we", 32'(dmem_we), 32'(!is_load));
      if (!is_load) check("wdata", dmem_wdata, exp_wd);
      step();
    end
    dmem_gnt = 1'b0;
    #1;
    check("wait_req", 32'(dmem_req), 32'd0);
    check("wait_stall", 32'(stall_o), 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    dmem_err    = err;
    step();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    flush_m     = 1'b0;
    #1;
    check("done_stall", 32'(stall_o), 32'd0);
    check("done_bus_err", 32'(bus_err_o), 32'(err));
    check("read_data", read_data_m, sb_q.pop_front());
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    step();
    check("idle_bus_err_clr", 32'(bus_err_o), 32'd0);
  endtask

  task automatic do_misalign(input logic [2:0] f3, input logic [31:0] addr);
    mem_read_m   = 1'b1;
    funct3_m     = f3;
    alu_result_m = addr;
    #1;
    check("mis_stall", 32'(stall_o), 32'd0);
    step();
    mem_read_m = 1'b0;
    #1;
    check("mis_pulse", 32'(misalign_o), 32'd1);
    check("mis_req", 32'(dmem_req), 32'd0);
    step();
    check("mis_pulse_clr", 32'(misalign_o), 32'd0);
    check("mis_req2", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    {mem_read_m, mem_write_m, flush_m, dmem_gnt, dmem_rvalid, dmem_err} = '0;
    funct3_m = 3'b010;
    alu_result_m = '0;
    write_data_m = '0;
    dmem_rdata = '0;
    repeat (2) step();
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_rd", read_data_m, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_mis", 32'(misalign_o), 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;
    step();

    do_access(1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
    do_access(1, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
    do_access(1, 3'b100, 32'h103, 32'h0, 1, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 32'h00000080, 0);
    do_access(0, 3'b001, 32'h202, 32'h0000ABCD, 4, 32'h55555555, 0, 4'b1100, 32'hABCDABCD,
              32'h00000080, 1);
    do_access(1, 3'b001, 32'h102, 32'h0, 0, 32'h80011234, 0, 4'b1100, 32'h0, 32'hFFFF8001, 0);
    do_access(1, 3'b101, 32'h100, 32'h0, 2, 32'h8001F234, 0, 4'b0011, 32'h0, 32'h0000F234, 0);
    do_access(0, 3'b000, 32'h001, 32'h0000005A, 0, 32'h0, 0, 4'b0010, 32'h5A5A5A5A,
              32'h0000F234, 0);
    do_access(0, 3'b010, 32'h010, 32'h11223344, 0, 32'hFFFFFFFF, 1, 4'b1111, 32'h11223344,
              32'h0000F234, 0);
    do_access(1, 3'b010, 32'h020, 32'h0, 0, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'h0, 0);
    do_access(1, 3'b010, 32'h024, 32'h0, 0, 32'h0BADF00D, 0, 4'b1111, 32'h0, 32'h0BADF00D, 0);

    do_misalign(3'b010, 32'h101);
    do_misalign(3'b001, 32'h001);
    do_misalign(3'b011, 32'h000);

    // A flushed instruction must not start a transaction.
    mem_read_m = 1'b1; flush_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h40;
    #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    step();
    check("flush_req", 32'(dmem_req), 32'd0);
    check("flush_mis", 32'(misalign_o), 32'd0);
    mem_read_m = 1'b0; flush_m = 1'b0;
    step();

    // Timeout: granted load with no response.
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h300;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    n = 0;
    while (stall_o && n < 200) begin
      step();
      n++;
    end
    check("to_cycles", 32'(n), 32'(TimeoutCyc - 1));
    check("to_bus_err", 32'(bus_err_o), 32'd1);
    check("to_rd", read_data_m, 32'd0);
    mem_read_m = 1'b0;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h77777777;
    step();
    dmem_rvalid = 1'b0;
    check("late_rd", read_data_m, 32'd0);
    check("late_err", 32'(bus_err_o), 32'd0);
    check("late_stall", 32'(stall_o), 32'd0);

    // Load with a known result so the reset clearing is observable.
    do_access(1, 3'b010, 32'h400, 32'h0, 0, 32'h13572468, 0, 4'b1111, 32'h0, 32'h13572468, 0);

    // Reset during WAIT.
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h500;
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("pre_rst_stall", 32'(stall_o), 32'd1);
    mem_read_m = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_rd", read_data_m, 32'd0);
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_rvalid = 1'b0;
    step();
    check("post_rst_rd", read_data_m, 32'd0);
    check("post_rst_err", 32'(bus_err_o), 32'd0);
    check("post_rst_stall", 32'(stall_o), 32'd0);
    check("post_rst_req", 32'(dmem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
